// File: rtl/fsm_txn_sched_if.sv
// fsm_txn_sched_if: requester and shared-FSM handshake bundle for the round-robin scheduler
interface fsm_txn_sched_if #(parameter int NREQ = 4);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] kind;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] gnt_id;
  logic done;
  logic err;
  logic busy;
  logic fsm_sig1;
  logic fsm_sig2;
  logic fsm_a;
  logic fsm_b;
  logic [15:0] txn_cnt;
  logic [7:0] err_cnt;
  modport master (
    output req, kind, fsm_a, fsm_b,
    input gnt, gnt_id, done, err, busy, fsm_sig1, fsm_sig2, txn_cnt, err_cnt
  );
  modport slave (
    input req, kind, fsm_a, fsm_b,
    output gnt, gnt_id, done, err, busy, fsm_sig1, fsm_sig2, txn_cnt, err_cnt
  );
endinterface

// File: rtl/fsm_txn_sched.sv
// fsm_txn_sched: round-robin scheduler sequencing a shared 3-state handshake FSM per grant
module fsm_txn_sched #(
  parameter int NREQ = 4,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst,
  fsm_txn_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [2:0] {IDLE, FIRE, CHECK, TAIL, REC1, REC2} state_t;
  state_t state;
  logic [IW-1:0] id, ptr, pick, nxt, j;
  logic [GW-1:0] gap;
  logic knd, found, fail;
  always_comb begin
    pick = ptr;
    found = 1'b0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (bus.req[j]) begin
        pick = j;
        found = 1'b1;
      end
    end
  end
  assign nxt = (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
  assign fail = (state == FIRE && !bus.fsm_a) || (state == CHECK && !bus.fsm_b) ||
                (state == TAIL && bus.fsm_b);
  // the cycle leaving TAIL/REC2 already has zero FSM inputs, so it counts as the first idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id <= '0;
      knd <= 1'b0;
      ptr <= '0;
      gap <= GW'(GAP);
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
      bus.fsm_sig1 <= 1'b0;
      bus.fsm_sig2 <= 1'b0;
      bus.txn_cnt <= '0;
      bus.err_cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      if (fail) begin
        state <= REC1;
        bus.err <= 1'b1;
        bus.err_cnt <= (bus.err_cnt == 8'hFF) ? bus.err_cnt : bus.err_cnt + 8'd1;
        ptr <= nxt;
        bus.fsm_sig1 <= 1'b0;
        bus.fsm_sig2 <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (gap != '0) gap <= gap - 1'b1;
            else if (found) begin
              state <= FIRE;
              id <= pick;
              knd <= bus.kind[pick];
              bus.gnt <= NREQ'(1) << pick;
              bus.gnt_id <= pick;
              bus.fsm_sig1 <= 1'b1;
              bus.busy <= 1'b1;
            end
          end
          FIRE: begin
            state <= CHECK;
            bus.fsm_sig1 <= 1'b0;
            bus.fsm_sig2 <= knd;
          end
          CHECK: begin
            state <= TAIL;
            bus.fsm_sig2 <= 1'b0;
          end
          TAIL: begin
            state <= IDLE;
            bus.done <= 1'b1;
            bus.txn_cnt <= (bus.txn_cnt == 16'hFFFF) ? bus.txn_cnt : bus.txn_cnt + 16'd1;
            ptr <= nxt;
            gap <= GW'(GAP - 1);
            bus.gnt <= '0;
            bus.busy <= 1'b0;
          end
          REC1: begin
            state <= REC2;
            bus.gnt <= '0;
          end
          default: begin
            state <= IDLE;
            gap <= GW'(GAP - 1);
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
